uart_tx_fifo: RTL

Parametrised UART transmitter, the successor to the fixed 8N1 sender. It adds configurable data width and oversample ratio, runtime parity and stop-bit selection, and a small transmit FIFO so the host can queue several words. It sits between the host write interface and the serial tx pin, clocked by the oversample clock.

---
 rtl/uart_tx_fifo.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a small transmit FIFO.
// The frame format is configurable: data width, oversample ratio, parity and stop bits.
// The parity mode and stop-bit count are captured when a word is popped, so a whole
// frame always uses one consistent format.
// After the final stop bit, the next queued word starts immediately with no idle gap.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk16x,
    input  logic                 rst,
    input  logic                 TransEn,
    input  logic [DATA_BITS-1:0] DataToTrans,
    input  logic [1:0]           ParityMode,
    input  logic                 TwoStop,
    output logic                 BufFull,
    output logic                 BufEmpty,
    output logic                 Overflow,
    output logic                 Busy,
    output logic                 tx
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    localparam logic [SW-1:0] SAMPLE_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(DATA_BITS - 1);
    localparam logic [CW-1:0] COUNT_FULL  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]        r_wptr;
    logic [PW-1:0]        r_rptr;
    logic [CW-1:0]        r_count;
    logic                 w_wr_ok;
    logic                 w_pop;
    logic                 w_empty;
    logic                 w_full;
    logic [DATA_BITS-1:0] w_head;

    // Transmit FSM state
    state_t               r_state;
    state_t               w_state_n;
    logic [SW-1:0]        r_sample;
    logic [SW-1:0]        w_sample_n;
    logic [BW-1:0]        r_bitcnt;
    logic [BW-1:0]        w_bitcnt_n;
    logic                 r_tx;
    logic                 w_tx_n;
    logic [1:0]           r_pmode;
    logic [1:0]           w_pmode_n;
    logic                 r_two;
    logic                 w_two_n;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_n;
    logic                 r_parbit;
    logic                 w_parbit_n;
    logic                 w_load;
    logic                 w_sample_last;
    logic                 w_par_en;

    assign w_full        = (r_count == COUNT_FULL);
    assign w_empty       = (r_count == '0);
    assign w_wr_ok       = TransEn && !w_full;
    assign w_head        = r_mem[r_rptr];
    assign w_sample_last = (r_sample == SAMPLE_LAST);
    assign w_par_en      = r_pmode[0] ^ r_pmode[1];

    assign BufFull  = w_full;
    assign BufEmpty = w_empty;
    assign Overflow = TransEn && w_full;
    assign Busy     = (r_state != S_IDLE);
    assign tx       = r_tx;

    // Store an accepted word at the write pointer (storage needs no reset)
    always_ff @(posedge clk16x) begin
        if (w_wr_ok) begin
            r_mem[r_wptr] <= DataToTrans;
        end
    end

    // Pointers wrap naturally because the depth is a power of two; count tracks occupancy
    always_ff @(posedge clk16x or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_wr_ok, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Next-state logic: walk start/data/parity/stop, reloading straight from the FIFO
    always_comb begin
        w_state_n  = r_state;
        w_sample_n = r_sample;
        w_bitcnt_n = r_bitcnt;
        w_tx_n     = r_tx;
        w_pmode_n  = r_pmode;
        w_two_n    = r_two;
        w_shift_n  = r_shift;
        w_parbit_n = r_parbit;
        w_pop      = 1'b0;
        w_load     = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_tx_n = 1'b1;
                if (!w_empty) begin
                    w_load = 1'b1;
                end
            end
            S_START: begin
                if (w_sample_last) begin
                    w_state_n  = S_DATA;
                    w_sample_n = '0;
                    w_bitcnt_n = '0;
                    w_tx_n     = r_shift[0];
                end else begin
                    w_sample_n = r_sample + SW'(1);
                end
            end
            S_DATA: begin
                if (w_sample_last) begin
                    w_sample_n = '0;
                    if (r_bitcnt == BIT_LAST) begin
                        w_bitcnt_n = '0;
                        if (w_par_en) begin
                            w_state_n = S_PARITY;
                            w_tx_n    = r_parbit;
                        end else begin
                            w_state_n = S_STOP;
                            w_tx_n    = 1'b1;
                        end
                    end else begin
                        // Bits leave LSB first; the next bit is the one above the current one
                        w_bitcnt_n = r_bitcnt + BW'(1);
                        w_shift_n  = r_shift >> 1;
                        w_tx_n     = r_shift[1];
                    end
                end else begin
                    w_sample_n = r_sample + SW'(1);
                end
            end
            S_PARITY: begin
                if (w_sample_last) begin
                    w_state_n  = S_STOP;
                    w_sample_n = '0;
                    w_bitcnt_n = '0;
                    w_tx_n     = 1'b1;
                end else begin
                    w_sample_n = r_sample + SW'(1);
                end
            end
            S_STOP: begin
                if (w_sample_last) begin
                    w_sample_n = '0;
                    if (r_two && (r_bitcnt == '0)) begin
                        // Count the first of two stop bits with the bit counter
                        w_bitcnt_n = BW'(1);
                    end else if (!w_empty) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_n = S_IDLE;
                        w_tx_n    = 1'b1;
                    end
                end else begin
                    w_sample_n = r_sample + SW'(1);
                end
            end
            default: begin
                w_state_n  = S_IDLE;
                w_sample_n = '0;
                w_bitcnt_n = '0;
                w_tx_n     = 1'b1;
            end
        endcase

        // Frame start: pop the head and capture this frame's format
        if (w_load) begin
            w_pop      = 1'b1;
            w_state_n  = S_START;
            w_sample_n = '0;
            w_bitcnt_n = '0;
            w_tx_n     = 1'b0;
            w_shift_n  = w_head;
            w_pmode_n  = ParityMode;
            w_two_n    = TwoStop;
            w_parbit_n = (^w_head) ^ (ParityMode == 2'b10);
        end
    end

    // Control registers of the transmitter; reset abandons any frame and idles the line
    always_ff @(posedge clk16x or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_sample <= '0;
            r_bitcnt <= '0;
            r_tx     <= 1'b1;
            r_pmode  <= 2'b00;
            r_two    <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_sample <= w_sample_n;
            r_bitcnt <= w_bitcnt_n;
            r_tx     <= w_tx_n;
            r_pmode  <= w_pmode_n;
            r_two    <= w_two_n;
        end
    end

    // Data shift register and precomputed parity bit (only meaningful during a frame)
    always_ff @(posedge clk16x) begin
        r_shift  <= w_shift_n;
        r_parbit <= w_parbit_n;
    end

endmodule
